// File: rtl/hsiao_ecc_enc_stream.sv
// hsiao_ecc_enc_stream: streaming multi-lane Hsiao SECDED encoder with one-shot error injection
package hsiao_ecc_pkg;
    localparam int MaxProt  = 16;
    localparam int MaxTotal = 1040;
    typedef logic [MaxProt-1:0][MaxTotal-1:0] matrix_t;
    // Data columns are distinct odd-weight vectors of weight >= 3, lowest weight first and
    // ascending value within a weight; check columns form the identity, so every column is odd.
    function automatic matrix_t hsiao_matrix(input int dw, input int pw);
        matrix_t m;
        int col;
        m = '0;
        col = 0;
        for (int w = 3; w <= pw; w += 2) begin
            for (int v = 0; v < (1 << pw); v++) begin
                if (col < dw && $countones(v) == w) begin
                    for (int i = 0; i < pw; i++) m[i][col] = v[i];
                    col++;
                end
            end
        end
        for (int i = 0; i < pw; i++) m[i][dw+i] = 1'b1;
        return m;
    endfunction
endpackage

module hsiao_ecc_enc_stream #(
    parameter int DataWidth  = 32,
    parameter int ProtWidth  = $clog2(DataWidth) + 2,
    parameter int TotalWidth = DataWidth + ProtWidth,
    parameter int NumLanes   = 1,
    parameter int CntWidth   = 16,
    localparam int LaneWidth = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NumLanes*DataWidth-1:0]  in_data_i,
    input  logic                           inj_valid_i,
    input  logic [LaneWidth-1:0]           inj_lane_i,
    input  logic [TotalWidth-1:0]          inj_mask_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NumLanes*TotalWidth-1:0] out_data_o,
    output logic [NumLanes-1:0]            out_injected_o,
    output logic [CntWidth-1:0]            beat_cnt_o
);
    localparam hsiao_ecc_pkg::matrix_t H = hsiao_ecc_pkg::hsiao_matrix(DataWidth, ProtWidth);

    if (ProtWidth < $clog2(DataWidth) + 2) begin : g_prot_chk
        $error("ProtWidth is below the SECDED minimum for DataWidth");
    end
    if (ProtWidth > hsiao_ecc_pkg::MaxProt || TotalWidth > hsiao_ecc_pkg::MaxTotal) begin : g_size_chk
        $error("Codeword exceeds the supported matrix size");
    end

    function automatic logic [TotalWidth-1:0] encode(input logic [DataWidth-1:0] d);
        logic [TotalWidth-1:0] c;
        c = '0;
        c[DataWidth-1:0] = d;
        for (int i = 0; i < ProtWidth; i++) c[DataWidth+i] = ^(d & H[i][DataWidth-1:0]);
        return c;
    endfunction

    logic                                 out_valid_q;
    logic [NumLanes*TotalWidth-1:0]       out_data_q, enc_d;
    logic [NumLanes-1:0]                  out_inj_q, inj_d, armed_q, armed_d;
    logic [NumLanes-1:0][TotalWidth-1:0]  mask_q, mask_d;
    logic [CntWidth-1:0]                  cnt_q, cnt_d;
    logic                                 accept;

    assign in_ready_o     = !out_valid_q || out_ready_i;
    assign accept         = in_valid_i && in_ready_o;
    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign out_injected_o = out_inj_q;
    assign beat_cnt_o     = cnt_q;
    assign cnt_d          = clear_i ? '0 : (accept && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // Per-lane encode plus injection: a same-cycle arm wins over the stored mask, clear vetoes all.
    always_comb begin : p_lanes
        logic arm, hit;
        logic [TotalWidth-1:0] m;
        enc_d   = '0;
        inj_d   = '0;
        armed_d = armed_q;
        mask_d  = mask_q;
        for (int l = 0; l < NumLanes; l++) begin
            arm = inj_valid_i && (inj_lane_i == LaneWidth'(l));
            hit = !clear_i && (arm || armed_q[l]);
            m = arm ? inj_mask_i : mask_q[l];
            inj_d[l] = hit;
            enc_d[l*TotalWidth +: TotalWidth] = encode(in_data_i[l*DataWidth +: DataWidth]) ^ (hit ? m : '0);
            mask_d[l] = (arm && !clear_i) ? inj_mask_i : mask_q[l];
            armed_d[l] = hit && !accept;
        end
    end

    // Output register: load on accept, drop valid on a drain-only handshake, hold otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_inj_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= enc_d;
            out_inj_q   <= inj_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Injection arming state and saturating beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            armed_q <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
        end else begin
            armed_q <= armed_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_hsiao_ecc_enc_stream.sv
// tb_hsiao_ecc_enc_stream: randomized and directed checks of the streaming Hsiao encoder
module tb_hsiao_ecc_enc_stream;
    localparam int DW = 32, PW = 7, TW = 39, NL = 4, LW = 2;

    logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, inj_valid = 1'b0, out_ready = 1'b0;
    logic [NL*DW-1:0] in_data = '0;
    logic [LW-1:0]    inj_lane = '0;
    logic [TW-1:0]    inj_mask = '0;
    logic             in_ready, out_valid, s_in_ready, s_out_valid;
    logic [NL*TW-1:0] out_data, s_out_data;
    logic [NL-1:0]    out_inj, s_out_inj;
    logic [15:0]      cnt;
    logic [3:0]       s_cnt;
    logic [PW-1:0]    cols [DW];
    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    hsiao_ecc_enc_stream #(.DataWidth(DW), .NumLanes(NL), .CntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .inj_valid_i(inj_valid), .inj_lane_i(inj_lane), .inj_mask_i(inj_mask),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_injected_o(out_inj), .beat_cnt_o(cnt));

    hsiao_ecc_enc_stream #(.DataWidth(DW), .NumLanes(NL), .CntWidth(4)) dut_s (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .in_valid_i(in_valid), .in_ready_o(s_in_ready),
        .in_data_i(in_data), .inj_valid_i(inj_valid), .inj_lane_i(inj_lane), .inj_mask_i(inj_mask),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_data_o(s_out_data),
        .out_injected_o(s_out_inj), .beat_cnt_o(s_cnt));

    // Reference code: check bits are the XOR of the matrix columns selected by the set data bits.
    function automatic logic [TW-1:0] enc(input logic [DW-1:0] d);
        logic [PW-1:0] p;
        p = '0;
        for (int k = 0; k < DW; k++) if (d[k]) p ^= cols[k];
        return {p, d};
    endfunction

    function automatic logic [NL*TW-1:0] enc_beat(input logic [NL*DW-1:0] d);
        logic [NL*TW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*TW +: TW] = enc(d[l*DW +: DW]);
        return r;
    endfunction

    function automatic logic [NL*DW-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [NL*DW-1:0] d);
        in_valid = 1'b1;
        in_data = d;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_inj !== '0 || cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h inj=%b cnt=%0d ready=%b, want 0/0/0/0/1", out_valid, out_data, out_inj, cnt, in_ready);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        send('0);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== '0 || out_inj !== '0) begin
            errors++;
            $display("FAIL zero: valid=%b data=%h inj=%b, want 1/0/0", out_valid, out_data, out_inj);
        end
    endtask

    task automatic test_onehot();
        logic [NL*DW-1:0] d;
        logic [PW-1:0] chk;
        for (int k = 0; k < DW; k++) begin
            d = '0;
            for (int l = 0; l < NL; l++) d[l*DW + k] = 1'b1;
            send(d);
            chk = out_data[DW +: PW];
            vectors++;
            if (out_data !== enc_beat(d)) begin
                errors++;
                $display("FAIL onehot[%0d]: got %h, want %h", k, out_data, enc_beat(d));
            end
            vectors++;
            if ($countones(chk) % 2 != 1 || $countones(chk) < 3) begin
                errors++;
                $display("FAIL onehot_weight[%0d]: column %b, want odd weight >= 3", k, chk);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [NL*DW-1:0] a, b;
        a = rnd_beat();
        b = rnd_beat();
        send(a);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = b;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== enc_beat(a)) begin
                errors++;
                $display("FAIL stall[%0d]: ready=%b valid=%b data=%h, want 0/1/%h", i, in_ready, out_valid, out_data, enc_beat(a));
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b, want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== enc_beat(b)) begin
            errors++;
            $display("FAIL release_next: valid=%b data=%h, want 1/%h", out_valid, out_data, enc_beat(b));
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_inject();
        logic [NL*DW-1:0] a;
        logic [NL*TW-1:0] e;
        logic [TW-1:0] m;
        out_ready = 1'b1;
        inj_valid = 1'b1;
        inj_lane = 2'd2;
        inj_mask = TW'(1) << 3;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        a = rnd_beat();
        send(a);
        e = enc_beat(a);
        e[2*TW + 3] = ~e[2*TW + 3];
        vectors++;
        if (out_data !== e || out_inj !== 4'b0100) begin
            errors++;
            $display("FAIL inject_hit: data=%h inj=%b, want %h/0100", out_data, out_inj, e);
        end
        a = rnd_beat();
        send(a);
        vectors++;
        if (out_data !== enc_beat(a) || out_inj !== 4'b0000) begin
            errors++;
            $display("FAIL inject_once: data=%h inj=%b, want %h/0000", out_data, out_inj, enc_beat(a));
        end
        m = {$urandom, $urandom};
        inj_valid = 1'b1;
        inj_lane = 2'd1;
        inj_mask = m;
        a = rnd_beat();
        send(a);
        inj_valid = 1'b0;
        e = enc_beat(a);
        e[TW +: TW] ^= m;
        vectors++;
        if (out_data !== e || out_inj !== 4'b0010) begin
            errors++;
            $display("FAIL inject_same_cycle: data=%h inj=%b, want %h/0010", out_data, out_inj, e);
        end
        a = rnd_beat();
        send(a);
        vectors++;
        if (out_data !== enc_beat(a) || out_inj !== 4'b0000) begin
            errors++;
            $display("FAIL inject_same_once: data=%h inj=%b, want %h/0000", out_data, out_inj, enc_beat(a));
        end
        inj_valid = 1'b1;
        inj_lane = 2'd3;
        inj_mask = '0;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        a = rnd_beat();
        send(a);
        vectors++;
        if (out_data !== enc_beat(a) || out_inj !== 4'b1000) begin
            errors++;
            $display("FAIL inject_zero_mask: data=%h inj=%b, want %h/1000", out_data, out_inj, enc_beat(a));
        end
    endtask

    task automatic test_clear();
        logic [NL*DW-1:0] a;
        inj_valid = 1'b1;
        inj_lane = 2'd0;
        inj_mask = '1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        clear = 1'b0;
        vectors++;
        if (cnt !== 16'd0) begin
            errors++;
            $display("FAIL clear_cnt: got %0d, want 0", cnt);
        end
        a = rnd_beat();
        send(a);
        vectors++;
        if (out_data !== enc_beat(a) || out_inj !== 4'b0000 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL clear_disarm: data=%h inj=%b cnt=%0d, want %h/0000/1", out_data, out_inj, cnt, enc_beat(a));
        end
        inj_valid = 1'b1;
        inj_lane = 2'd1;
        inj_mask = '1;
        @(posedge clk);
        #1;
        inj_valid = 1'b0;
        clear = 1'b1;
        a = rnd_beat();
        send(a);
        clear = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== enc_beat(a) || out_inj !== 4'b0000 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL clear_with_beat: valid=%b data=%h inj=%b cnt=%0d, want 1/%h/0000/0", out_valid, out_data, out_inj, cnt, enc_beat(a));
        end
    endtask

    task automatic test_reset_mid();
        send(rnd_beat());
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b ready=%b cnt=%0d, want 0/1/0", out_valid, in_ready, cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: valid=%b ready=%b, want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [NL*TW-1:0] q[$];
        logic [NL*TW-1:0] e;
        int sent = 0, cycles = 0;
        while ((sent < 1000 || q.size() > 0) && cycles < 20000) begin
            in_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
            in_data = rnd_beat();
            out_ready = (sent >= 1000) || ($urandom_range(0, 9) < 7);
            @(negedge clk);
            vectors++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL rand_ready: got %b, want %b", in_ready, !out_valid || out_ready);
            end
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: got beat %h, want none", out_data);
                end else begin
                    e = q.pop_front();
                    if (out_data !== e || out_inj !== '0) begin
                        errors++;
                        $display("FAIL rand_beat: got %h inj=%b, want %h inj=0", out_data, out_inj, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(enc_beat(in_data));
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        vectors++;
        if (cycles >= 20000) begin
            errors++;
            $display("FAIL rand_timeout: sent=%0d pending=%0d, want 1000/0", sent, q.size());
        end
        vectors++;
        if (cnt !== 16'd1000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_count: cnt=%0d valid=%b, want 1000/0", cnt, out_valid);
        end
    endtask

    task automatic test_saturate();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 20; i++) begin
            send(rnd_beat());
            if (i == 14 || i == 15 || i == 20) begin
                vectors++;
                if (s_cnt !== 4'((i > 15) ? 15 : i) || cnt !== 16'(i)) begin
                    errors++;
                    $display("FAIL saturate[%0d]: cnt4=%0d cnt16=%0d, want %0d/%0d", i, s_cnt, cnt, (i > 15) ? 15 : i, i);
                end
            end
        end
    endtask

    initial begin
        int n;
        n = 0;
        for (int w = 3; w <= PW; w += 2)
            for (int v = 0; v < (1 << PW); v++)
                if ($countones(v) == w && n < DW) begin
                    cols[n] = PW'(v);
                    n++;
                end
        test_reset();
        test_zero();
        test_onehot();
        test_backpressure();
        test_inject();
        test_clear();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
